// File: rtl/l2_way_ctrl_pkg.sv
// Shared types for the L2 way controller.
package l2_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } l2_state_t;

endpackage

// File: rtl/l2_way_ctrl_if.sv
// Request/response bundle between the L2 datapath, pmem port and way controller.
interface l2_way_ctrl_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
);
  logic             mem_read;
  logic             mem_write;
  logic [IDX_W-1:0] index;
  logic [WAYS-1:0]  tagcmp;
  logic             pmem_resp;
  logic [WAYS-1:0]  hit;
  logic             hit_any;
  logic             mem_resp;
  logic [WAYS-1:0]  tag_we;
  logic [WAYS-1:0]  data_we;
  logic [WAY_W-1:0] victim_way;
  logic             pmem_read;
  logic             pmem_write;

  // Datapath / pmem side: issues requests, comparator results and pmem responses.
  modport master (
    output mem_read, mem_write, index, tagcmp, pmem_resp,
    input  hit, hit_any, mem_resp, tag_we, data_we, victim_way, pmem_read, pmem_write
  );

  // Controller side.
  modport slave (
    input  mem_read, mem_write, index, tagcmp, pmem_resp,
    output hit, hit_any, mem_resp, tag_we, data_we, victim_way, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_way_ctrl_plru_tree.sv
// Combinational tree-PLRU for one set. Node n (heap order, 1..WAYS-1) holds 0
// when the victim lies in its lower subtree and 1 when it lies in the upper one.
module l2_plru_tree #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:1]  bits_in,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAYS-1:1]  bits_out,
  output logic [WAY_W-1:0] victim
);
  logic [WAY_W:0] upd_node_s;
  logic [WAY_W:0] vic_node_s;

  // Walk the tree twice: point nodes on the accessed path away from it, and follow node bits to the victim leaf.
  always_comb begin
    upd_node_s = {{WAY_W{1'b0}}, 1'b1};
    vic_node_s = {{WAY_W{1'b0}}, 1'b1};
    bits_out   = bits_in;
    for (int l = 0; l < WAY_W; l++) begin
      bits_out[upd_node_s[WAY_W-1:0]] = ~access_way[WAY_W-1-l];
      upd_node_s = {upd_node_s[WAY_W-1:0], access_way[WAY_W-1-l]};
      vic_node_s = {vic_node_s[WAY_W-1:0], bits_in[vic_node_s[WAY_W-1:0]]};
    end
    // Leaf node numbers are WAYS..2*WAYS-1, so the low bits are the way.
    victim = vic_node_s[WAY_W-1:0];
  end
endmodule

// File: rtl/l2_way_ctrl.sv
// L2 way controller: per-set valid/dirty/PLRU state, hit detection, victim
// choice and write-back/allocate sequencing towards physical memory.
module l2_way_ctrl
  import l2_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input logic         clk,
  input logic         rst,
  l2_way_ctrl_if.slave bus
);
  l2_state_t        state_r;
  logic [WAYS-1:0]  valid_r [SETS];
  logic [WAYS-1:0]  dirty_r [SETS];
  logic [WAYS-1:1]  plru_r  [SETS];
  logic [WAY_W-1:0] victim_way_r;
  logic             pmem_read_r;
  logic             pmem_write_r;

  logic             req_s;
  logic [WAYS-1:0]  valid_set_s;
  logic [WAYS-1:0]  dirty_set_s;
  logic [WAYS-1:0]  hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] inv_way_s;
  logic             inv_found_s;
  logic [WAY_W-1:0] miss_victim_s;
  logic [WAY_W-1:0] plru_access_s;
  logic [WAYS-1:1]  plru_next_s;
  logic [WAY_W-1:0] plru_victim_s;
  logic [WAYS-1:0]  victim_oh_s;

  assign req_s       = bus.mem_read | bus.mem_write;
  assign valid_set_s = valid_r[bus.index];
  assign dirty_set_s = dirty_r[bus.index];
  assign victim_oh_s = {{(WAYS-1){1'b0}}, 1'b1} << victim_way_r;

  // Hit vector and its encoded way, plus the lowest-numbered invalid way of the set.
  always_comb begin
    hit_s       = {WAYS{1'b0}};
    hit_way_s   = {WAY_W{1'b0}};
    inv_way_s   = {WAY_W{1'b0}};
    inv_found_s = 1'b0;
    if ((state_r == IDLE) && req_s) begin
      hit_s = valid_set_s & bus.tagcmp;
    end else begin
      hit_s = {WAYS{1'b0}};
    end
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s = hit_s[w] ? WAY_W'(w) : hit_way_s;
    end
    // Descending scan so the lowest invalid way is the one left standing.
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_way_s   = valid_set_s[w] ? inv_way_s : WAY_W'(w);
      inv_found_s = inv_found_s | ~valid_set_s[w];
    end
  end

  // PLRU is touched by the hit way in IDLE and by the latched victim on allocate.
  always_comb begin
    if (state_r == IDLE) begin
      plru_access_s = hit_way_s;
    end else begin
      plru_access_s = victim_way_r;
    end
    if (inv_found_s) begin
      miss_victim_s = inv_way_s;
    end else begin
      miss_victim_s = plru_victim_s;
    end
  end

  l2_plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .bits_in    (plru_r[bus.index]),
    .access_way (plru_access_s),
    .bits_out   (plru_next_s),
    .victim     (plru_victim_s)
  );

  // Array write enables and the request completion, decoded from state and current inputs.
  always_comb begin
    bus.tag_we   = {WAYS{1'b0}};
    bus.data_we  = {WAYS{1'b0}};
    bus.mem_resp = 1'b0;
    case (state_r)
      IDLE: begin
        bus.mem_resp = |hit_s;
        if (bus.mem_write) begin
          bus.data_we = hit_s;
        end else begin
          bus.data_we = {WAYS{1'b0}};
        end
      end
      ALLOCATE: begin
        if (bus.pmem_resp) begin
          bus.tag_we  = victim_oh_s;
          bus.data_we = victim_oh_s;
        end else begin
          bus.tag_we  = {WAYS{1'b0}};
          bus.data_we = {WAYS{1'b0}};
        end
      end
      default: begin
        bus.tag_we   = {WAYS{1'b0}};
        bus.data_we  = {WAYS{1'b0}};
        bus.mem_resp = 1'b0;
      end
    endcase
  end

  assign bus.hit        = hit_s;
  assign bus.hit_any    = |hit_s;
  assign bus.victim_way = victim_way_r;
  assign bus.pmem_read  = pmem_read_r;
  assign bus.pmem_write = pmem_write_r;

  // Sequencer: owns all per-set state, the latched victim and the pmem strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      victim_way_r <= {WAY_W{1'b0}};
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        dirty_r[s] <= {WAYS{1'b0}};
        plru_r[s]  <= {(WAYS-1){1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && (|hit_s)) begin
            plru_r[bus.index] <= plru_next_s;
            if (bus.mem_write) begin
              dirty_r[bus.index] <= dirty_set_s | hit_s;
            end
          end else if (req_s) begin
            victim_way_r <= miss_victim_s;
            if (valid_set_s[miss_victim_s] && dirty_set_s[miss_victim_s]) begin
              state_r      <= WRITEBACK;
              pmem_write_r <= 1'b1;
            end else begin
              state_r     <= ALLOCATE;
              pmem_read_r <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            dirty_r[bus.index][victim_way_r] <= 1'b0;
            state_r      <= ALLOCATE;
            pmem_write_r <= 1'b0;
            pmem_read_r  <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            valid_r[bus.index][victim_way_r] <= 1'b1;
            dirty_r[bus.index][victim_way_r] <= 1'b0;
            plru_r[bus.index] <= plru_next_s;
            state_r     <= IDLE;
            pmem_read_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          pmem_read_r  <= 1'b0;
          pmem_write_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l2_way_ctrl.sv
// Directed bench for l2_way_ctrl (WAYS=4, SETS=8): a vector table for the
// cold-fill sequence, then hand-written miss/write-back/reset sequences.
module tb_l2_way_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  l2_way_ctrl_if #(.WAYS(4), .SETS(8)) bus ();

  l2_way_ctrl #(.WAYS(4), .SETS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rd;
    logic       wr;
    logic [2:0] idx;
    logic [3:0] tc;
    logic       resp;
    logic [3:0] e_hit;
    logic       e_mresp;
    logic [3:0] e_twe;
    logic [3:0] e_dwe;
    logic       e_prd;
    logic       e_pwr;
    logic [1:0] e_vic;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] idx,
                       input logic [3:0] tc, input logic resp);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.index     = idx;
    bus.tagcmp    = tc;
    bus.pmem_resp = resp;
  endtask

  // Full miss: optional write-back, allocate of exp_vic, then the re-lookup hit.
  task automatic do_miss(input logic [2:0] idx, input logic wr,
                         input logic [1:0] exp_vic, input logic exp_wb);
    logic [3:0] oh;
    oh = 4'b0001 << exp_vic;
    drive(~wr, wr, idx, 4'b0000, 1'b0);
    @(negedge clk);
    chk("miss_hit_any", bus.hit_any, 1'b0);
    chk("miss_mem_resp", bus.mem_resp, 1'b0);
    @(posedge clk); #1;
    chk("miss_victim_way", bus.victim_way, exp_vic);
    if (exp_wb) begin
      chk("wb_pmem_write", bus.pmem_write, 1'b1);
      chk("wb_pmem_read", bus.pmem_read, 1'b0);
      @(posedge clk); #1;
      chk("wb_hold", bus.pmem_write, 1'b1);
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      chk("wb_no_we", {bus.tag_we, bus.data_we}, 8'h00);
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      chk("wb_drop", bus.pmem_write, 1'b0);
    end
    chk("alloc_pmem_read", bus.pmem_read, 1'b1);
    chk("alloc_pmem_write", bus.pmem_write, 1'b0);
    @(posedge clk); #1;
    chk("alloc_hold", bus.pmem_read, 1'b1);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    chk("alloc_tag_we", bus.tag_we, oh);
    chk("alloc_data_we", bus.data_we, oh);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    bus.tagcmp    = oh;
    @(negedge clk);
    chk("relookup_hit", bus.hit, oh);
    chk("relookup_mem_resp", bus.mem_resp, 1'b1);
    chk("relookup_pmem_read", bus.pmem_read, 1'b0);
    chk("relookup_data_we", bus.data_we, wr ? oh : 4'b0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, idx, 4'b0000, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 1'b0, 3'd0, 4'b0000, 1'b0);
    rst = 1'b1;

    //            rd    wr    idx   tc       resp  e_hit    mrsp  e_twe    e_dwe    prd   pwr   vic
    vecs[0]  = '{1'b0, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 3'd3, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1};

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs", {bus.hit, bus.hit_any, bus.mem_resp, bus.tag_we, bus.data_we,
                        bus.victim_way, bus.pmem_read, bus.pmem_write}, 21'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold fill of index 3, ways 0 and 1.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].idx, vecs[i].tc, vecs[i].resp);
      @(negedge clk);
      chk($sformatf("vec%0d_hit", i), bus.hit, vecs[i].e_hit);
      chk($sformatf("vec%0d_hit_any", i), bus.hit_any, |vecs[i].e_hit);
      chk($sformatf("vec%0d_mem_resp", i), bus.mem_resp, vecs[i].e_mresp);
      chk($sformatf("vec%0d_tag_we", i), bus.tag_we, vecs[i].e_twe);
      chk($sformatf("vec%0d_data_we", i), bus.data_we, vecs[i].e_dwe);
      chk($sformatf("vec%0d_pmem_read", i), bus.pmem_read, vecs[i].e_prd);
      chk($sformatf("vec%0d_pmem_write", i), bus.pmem_write, vecs[i].e_pwr);
      chk($sformatf("vec%0d_victim_way", i), bus.victim_way, vecs[i].e_vic);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 3'd3, 4'b0000, 1'b0);

    // Invalid-first fill of ways 2 and 3, then PLRU picks way 2 after a hit on way 0.
    do_miss(3'd3, 1'b0, 2'd2, 1'b0);
    do_miss(3'd3, 1'b0, 2'd3, 1'b0);
    drive(1'b1, 1'b0, 3'd3, 4'b0001, 1'b0);
    @(negedge clk);
    chk("idx3_hit_way0", bus.hit, 4'b0001);
    @(posedge clk); #1;
    do_miss(3'd3, 1'b0, 2'd2, 1'b0);

    // Index 5: write miss dirties way 0, fill the rest, then a dirty eviction.
    do_miss(3'd5, 1'b1, 2'd0, 1'b0);
    do_miss(3'd5, 1'b0, 2'd1, 1'b0);
    do_miss(3'd5, 1'b0, 2'd2, 1'b0);
    do_miss(3'd5, 1'b0, 2'd3, 1'b0);
    do_miss(3'd5, 1'b0, 2'd0, 1'b1);
    // Walk PLRU back round to way 0: it must now evict clean.
    do_miss(3'd5, 1'b0, 2'd2, 1'b0);
    do_miss(3'd5, 1'b0, 2'd1, 1'b0);
    do_miss(3'd5, 1'b0, 2'd3, 1'b0);
    do_miss(3'd5, 1'b0, 2'd0, 1'b0);

    // Read and write together on a hit behaves as a write and marks the line dirty.
    do_miss(3'd1, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 3'd1, 4'b0001, 1'b0);
    @(negedge clk);
    chk("rw_hit_data_we", bus.data_we, 4'b0001);
    chk("rw_hit_mem_resp", bus.mem_resp, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd1, 4'b0000, 1'b0);
    do_miss(3'd1, 1'b0, 2'd1, 1'b0);
    do_miss(3'd1, 1'b0, 2'd2, 1'b0);
    do_miss(3'd1, 1'b0, 2'd3, 1'b0);
    do_miss(3'd1, 1'b0, 2'd0, 1'b1);

    // pmem_resp while idle is ignored.
    drive(1'b0, 1'b0, 3'd1, 4'b0000, 1'b1);
    @(negedge clk);
    chk("idle_resp_outputs", {bus.tag_we, bus.data_we, bus.mem_resp, bus.pmem_read, bus.pmem_write}, 11'h0);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    chk("idle_resp_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
    drive(1'b1, 1'b0, 3'd1, 4'b0001, 1'b0);
    @(negedge clk);
    chk("idle_resp_then_hit", bus.hit, 4'b0001);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd1, 4'b0000, 1'b0);

    // Reset in the middle of an allocate.
    drive(1'b1, 1'b0, 3'd6, 4'b0000, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_pmem_read", bus.pmem_read, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd6, 4'b0000, 1'b0);
    chk("post_rst_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("post_rst_victim", bus.victim_way, 2'd0);
    // Way 0 of index 5 was valid before reset; the match must no longer hit.
    drive(1'b1, 1'b0, 3'd5, 4'b0001, 1'b0);
    @(negedge clk);
    chk("post_rst_no_hit", bus.hit, 4'b0000);
    chk("post_rst_no_resp", bus.mem_resp, 1'b0);
    drive(1'b0, 1'b0, 3'd5, 4'b0000, 1'b0);
    @(posedge clk); #1;
    do_miss(3'd5, 1'b0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l2_way_ctrl.md
# l2_way_ctrl

Parametrised N-way, S-set cache way controller for the L2: owns valid, dirty and tree-PLRU state for every set, detects hits from external tag comparators, selects a victim, and sequences write-back and allocate transactions with physical memory. It sits between the L2 datapath (tag/data arrays, comparators) and the pmem port, and generates all per-way array write enables.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, at least 2
- SETS, 8, number of sets; power of two
- IDX_W, $clog2(SETS), set index width (derived)
- WAY_W, $clog2(WAYS), way number width (derived)

Ports:
- clk  in  1  clock; single clock domain, all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- mem_read  in  1  read request; held until mem_resp
- mem_write  in  1  write request; held until mem_resp
- index  in  IDX_W  set index of the request; stable while a request is held
- tagcmp  in  WAYS  per-way tag match from datapath comparators
- pmem_resp  in  1  pmem transaction done
- hit  out  WAYS  one-hot hit vector
- hit_any  out  1  OR of hit
- mem_resp  out  1  request complete
- tag_we  out  WAYS  tag array write enable
- data_we  out  WAYS  data array write enable
- victim_way  out  WAY_W  latched victim; selects write-back tag/data mux
- pmem_read  out  1  allocate read in progress
- pmem_write  out  1  write-back in progress

## Operation
- req = mem_read | mem_write; mem_read and mem_write both high is treated as a write.
- hit[w] = valid[index][w] & tagcmp[w] & (state == IDLE) & req.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit: mem_resp=1; PLRU of set updated toward the hit way; if write: data_we[w]=1, dirty[index][w] set.
- IDLE, miss: victim = lowest-numbered invalid way in set, else PLRU victim; latched into victim_way. Next state WRITEBACK if victim valid & dirty, else ALLOCATE. No mem_resp.
- WRITEBACK: pmem_write=1 until pmem_resp; on pmem_resp, clear dirty[index][victim], go to ALLOCATE.
- ALLOCATE: pmem_read=1 until pmem_resp; on pmem_resp: tag_we[victim]=data_we[victim]=1, valid set, dirty cleared, PLRU updated toward victim, go to IDLE. The held request then re-looks up and hits.
- Tree-PLRU: WAYS-1 bits per set, heap-indexed nodes 1..WAYS-1. Bit 0 points to the lower half as victim. Access to way w sets every node on its path to point away from w.
- pmem_resp in IDLE is ignored.

## Timing
- Reset values: state IDLE; all valid, dirty and PLRU bits 0; victim_way 0; every output 0.
- Hit latency: mem_resp in the same cycle as the request (combinational from index/tagcmp).
- Clean miss: 1 cycle in IDLE, then ALLOCATE until pmem_resp, then hit in IDLE. Dirty miss adds the WRITEBACK phase first.
- pmem_read and pmem_write are never high together. They drop in the cycle after pmem_resp is sampled.
- rst mid-transaction, including during WRITEBACK or ALLOCATE: state is forced to IDLE at that edge. pmem_read and pmem_write are 0 in the following cycle, and all lines become invalid.
- Outputs are functions of the registered state plus current inputs; no output depends on pmem_resp outside WRITEBACK and ALLOCATE.

## Structure
- Package l2_pkg: l2_state_t enum (IDLE, WRITEBACK, ALLOCATE).
- Sub-module l2_plru_tree (combinational), parametrised by WAYS:
  - inputs: tree bits and access way
  - outputs: updated bits and victim way
- The controller instantiates l2_plru_tree once, for the addressed set.

## Test plan
(WAYS=4, SETS=8 unless stated)
- Cold read, index 3, tagcmp=0000 after reset -> victim 0, pmem_read high until pmem_resp; tag_we=0001 and data_we=0001 in the resp cycle; next cycle with tagcmp=0001 gives hit=0001 and mem_resp=1.
- Four misses to index 3 -> victim_way sequence 0,1,2,3 (invalid-first), no pmem_write.
- Then read hit way 0, then miss in index 3 -> victim_way=2 (PLRU).
- Index 5:
  - Write miss -> allocate way 0, then write hit: data_we=0001, dirty set.
  - Read-fill ways 1..3, then miss -> victim 0 dirty; pmem_write phase precedes pmem_read.
  - After completion, dirty[5][0]=0.
- rst asserted in ALLOCATE with pmem_read=1 -> next cycle pmem_read=0, state IDLE; re-read of the same index misses (valid cleared).
- mem_read=mem_write=1 on a hit -> data_we set and dirty marked. pmem_resp pulsed in IDLE -> no state change, no enables.
